// File: rtl/axi_transaction.sv
// Shared AXI-lite transaction types used by the master/slave pair.
package axi_transaction;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int ID_W   = 4;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ID_W-1:0]   id_t;

    typedef struct packed {
        id_t   id;
        addr_t addr;
    } ar_req_t;

endpackage

// File: rtl/axi_sync_fifo.sv
// Synchronous FIFO with count register; no fall-through when empty.
module axi_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = store[rptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) store[wptr] <= din;
    end

endmodule

// File: rtl/axi_slave_mem.sv
// AXI-lite style memory target: AW/W/AR buffered independently,
// single outstanding B and R register each.
module axi_slave_mem
    import axi_transaction::*;
#(
    parameter int MEM_DEPTH  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic  clk,
    input  logic  rst,
    input  addr_t araddr,
    input  id_t   arid,
    input  logic  arvalid,
    output logic  arready,
    input  addr_t awaddr,
    input  logic  awvalid,
    output logic  awready,
    input  data_t wdata,
    input  logic  wvalid,
    output logic  wready,
    output data_t rdata,
    output id_t   rid,
    output logic  rvalid,
    input  logic  rready,
    output logic  bvalid,
    input  logic  bready
);

    localparam int IW = $clog2(MEM_DEPTH);

    data_t   mem [MEM_DEPTH];
    ar_req_t ar_head;
    addr_t   aw_head;
    data_t   w_head;
    logic    ar_full, ar_empty;
    logic    aw_full, aw_empty;
    logic    w_full,  w_empty;
    logic    commit;
    logic    serve;
    logic [IW-1:0] aw_idx;
    logic [IW-1:0] ar_idx;
    logic    unused_bits;

    assign arready = !ar_full;
    assign awready = !aw_full;
    assign wready  = !w_full;

    assign commit = !aw_empty && !w_empty && (!bvalid || bready);
    assign serve  = !ar_empty && (!rvalid || rready);

    // Upper and byte-lane address bits are ignored: accesses wrap.
    assign aw_idx = aw_head[IW+1:2];
    assign ar_idx = ar_head.addr[IW+1:2];
    assign unused_bits = ^{aw_head[ADDR_W-1:IW+2], aw_head[1:0],
                           ar_head.addr[ADDR_W-1:IW+2], ar_head.addr[1:0]};

    axi_sync_fifo #(.WIDTH(ID_W+ADDR_W), .DEPTH(FIFO_DEPTH)) u_ar (
        .clk   (clk),
        .rst   (rst),
        .push  (arvalid),
        .din   ({arid, araddr}),
        .pop   (serve),
        .dout  (ar_head),
        .full  (ar_full),
        .empty (ar_empty)
    );

    axi_sync_fifo #(.WIDTH(ADDR_W), .DEPTH(FIFO_DEPTH)) u_aw (
        .clk   (clk),
        .rst   (rst),
        .push  (awvalid),
        .din   (awaddr),
        .pop   (commit),
        .dout  (aw_head),
        .full  (aw_full),
        .empty (aw_empty)
    );

    axi_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_w (
        .clk   (clk),
        .rst   (rst),
        .push  (wvalid),
        .din   (wdata),
        .pop   (commit),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bvalid <= 1'b0;
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
        end else if (commit) begin
            mem[aw_idx] <= w_head;
            bvalid      <= 1'b1;
        end else if (bready) begin
            bvalid <= 1'b0;
        end
    end

    // Reads sample mem before this edge's commit lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            rid    <= '0;
        end else if (serve) begin
            rvalid <= 1'b1;
            rdata  <= mem[ar_idx];
            rid    <= ar_head.id;
        end else if (rready) begin
            rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed self-checking bench for axi_slave_mem.
module tb_axi_slave_mem;
    import axi_transaction::*;

    logic  clk = 1'b0;
    logic  rst;
    addr_t araddr;
    id_t   arid;
    logic  arvalid;
    logic  arready;
    addr_t awaddr;
    logic  awvalid;
    logic  awready;
    data_t wdata;
    logic  wvalid;
    logic  wready;
    data_t rdata;
    id_t   rid;
    logic  rvalid;
    logic  rready;
    logic  bvalid;
    logic  bready;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    axi_slave_mem #(.MEM_DEPTH(16), .FIFO_DEPTH(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .araddr  (araddr),
        .arid    (arid),
        .arvalid (arvalid),
        .arready (arready),
        .awaddr  (awaddr),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wvalid  (wvalid),
        .wready  (wready),
        .rdata   (rdata),
        .rid     (rid),
        .rvalid  (rvalid),
        .rready  (rready),
        .bvalid  (bvalid),
        .bready  (bready)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // AR handshake then exact one-cycle latency to R, rready assumed 1.
    task automatic do_read(input string tag, input addr_t a, input id_t id,
                           input data_t exp);
        araddr  = a;
        arid    = id;
        arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        tick();
        check({tag, "_rvalid"}, 64'(rvalid), 64'd1);
        check({tag, "_rdata"}, 64'(rdata), 64'(exp));
        check({tag, "_rid"}, 64'(rid), 64'(id));
        tick();
    endtask

    task automatic write_both(input addr_t a, input data_t d);
        awaddr  = a;
        wdata   = d;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        tick();
        awvalid = 1'b0;
        wvalid  = 1'b0;
    endtask

    int  nb;
    logic hs;

    initial begin
        rst = 1'b1;
        {araddr, arid, arvalid, awaddr, awvalid, wdata, wvalid} = '0;
        rready = 1'b1;
        bready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();

        check("rst_rvalid", 64'(rvalid), 64'd0);
        check("rst_bvalid", 64'(bvalid), 64'd0);
        check("rst_rdata", 64'(rdata), 64'd0);
        check("rst_rid", 64'(rid), 64'd0);
        check("rst_readies", 64'({arready, awready, wready}), 64'b111);

        // single write then read
        write_both(32'h08, 32'hDEADBEEF);
        check("wr1_b_n", 64'(bvalid), 64'd0);
        tick();
        check("wr1_b_n1", 64'(bvalid), 64'd1);
        tick();
        check("wr1_b_clr", 64'(bvalid), 64'd0);
        do_read("rd1", 32'h08, 4'd3, 32'hDEADBEEF);

        // W leads AW by 5
        wdata  = 32'h11;
        wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("skw_b_early", 64'(bvalid), 64'd0);
            tick();
        end
        awaddr  = 32'h04;
        awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        check("skw_b_n5", 64'(bvalid), 64'd0);
        tick();
        check("skw_b_n6", 64'(bvalid), 64'd1);
        tick();
        do_read("skw_rd", 32'h04, 4'd1, 32'h11);

        // AW leads W by 3
        awaddr  = 32'h0C;
        awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        tick();
        tick();
        check("skw2_b_early", 64'(bvalid), 64'd0);
        wdata  = 32'h22;
        wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        check("skw2_b_n3", 64'(bvalid), 64'd0);
        tick();
        check("skw2_b_n4", 64'(bvalid), 64'd1);
        tick();
        do_read("skw2_rd", 32'h0C, 4'd2, 32'h22);

        // backpressure fill: 5 accepted, 6th waits
        bready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            awaddr  = 32'h10 + 32'(4 * i);
            wdata   = 32'hA0 + 32'(i);
            awvalid = 1'b1;
            wvalid  = 1'b1;
            tick();
        end
        check("bp_awready", 64'(awready), 64'd0);
        check("bp_wready", 64'(wready), 64'd0);
        check("bp_bvalid", 64'(bvalid), 64'd1);
        awaddr = 32'h24;
        wdata  = 32'hA5;
        bready = 1'b1;
        nb = 0;
        for (int c = 0; c < 6; c++) begin
            if (bvalid) nb++;
            hs = awvalid && awready;
            tick();
            if (hs) begin
                awvalid = 1'b0;
                wvalid  = 1'b0;
            end
        end
        check("bp_b_count", 64'(nb), 64'd6);
        check("bp_w5_taken", 64'(awvalid), 64'd0);
        tick();
        check("bp_b_drain", 64'(bvalid), 64'd0);
        for (int i = 0; i < 6; i++)
            do_read("bp_rd", 32'h10 + 32'(4 * i), 4'(i), 32'hA0 + 32'(i));

        // address wrap
        write_both(32'h40, 32'h55);
        tick();
        tick();
        do_read("wrap_rd", 32'h00, 4'd7, 32'h55);

        // same-edge read and commit to index 0
        awaddr  = 32'h00;
        wdata   = 32'h66;
        araddr  = 32'h00;
        arid    = 4'd9;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        arvalid = 1'b1;
        tick();
        {awvalid, wvalid, arvalid} = '0;
        tick();
        check("col_rvalid", 64'(rvalid), 64'd1);
        check("col_bvalid", 64'(bvalid), 64'd1);
        check("col_old", 64'(rdata), 64'h55);
        tick();
        do_read("col_new", 32'h00, 4'd4, 32'h66);

        // read stall then drain
        rready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            araddr  = 32'(4 * (i - 1));
            arid    = 4'(i);
            arvalid = 1'b1;
            tick();
        end
        arvalid = 1'b0;
        tick();
        tick();
        check("stl_rvalid", 64'(rvalid), 64'd1);
        check("stl_rid", 64'(rid), 64'd1);
        check("stl_rdata", 64'(rdata), 64'h66);
        rready = 1'b1;
        tick();
        check("stl_rid2", 64'(rid), 64'd2);
        check("stl_rdata2", 64'(rdata), 64'h11);
        tick();
        check("stl_rid3", 64'(rid), 64'd3);
        check("stl_rdata3", 64'(rdata), 64'hDEADBEEF);
        tick();
        check("stl_done", 64'(rvalid), 64'd0);

        // reset mid-operation
        bready  = 1'b0;
        rready  = 1'b0;
        araddr  = 32'h00;
        arid    = 4'd5;
        arvalid = 1'b1;
        write_both(32'h04, 32'h77);
        arvalid = 1'b0;
        write_both(32'h08, 32'h88);
        tick();
        check("mid_pre_rvalid", 64'(rvalid), 64'd1);
        check("mid_pre_bvalid", 64'(bvalid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rvalid", 64'(rvalid), 64'd0);
        check("mid_bvalid", 64'(bvalid), 64'd0);
        check("mid_readies", 64'({arready, awready, wready}), 64'b111);
        @(negedge clk);
        rst    = 1'b0;
        bready = 1'b1;
        rready = 1'b1;
        tick();
        tick();
        check("post_bvalid", 64'(bvalid), 64'd0);
        check("post_rvalid", 64'(rvalid), 64'd0);
        do_read("post_rd0", 32'h00, 4'd1, 32'h0);
        do_read("post_rd4", 32'h04, 4'd2, 32'h0);
        do_read("post_rd8", 32'h08, 4'd3, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
